// File: rtl/zilla_muldiv_pkg.sv
// Shared types for the RV32M multiply/divide scheduler: FSM states,
// funct3 op codes and writeback result-mux select codes.
package zilla_muldiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_WB   = 2'b11
    } state_e;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        WB_MUL    = 2'b00,
        WB_QUOT   = 2'b01,
        WB_REM    = 2'b10,
        WB_BYPASS = 2'b11
    } wb_src_e;

    // Divide-by-zero results are produced by the bypass path, not the divider.
    function automatic wb_src_e op_to_src(input logic [2:0] op, input logic div_zero);
        wb_src_e src;
        case (op)
            OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: src = WB_MUL;
            OP_DIV, OP_DIVU:                      src = WB_QUOT;
            OP_REM, OP_REMU:                      src = WB_REM;
            default:                              src = WB_MUL;
        endcase
        if (op[2] && div_zero) begin
            src = WB_BYPASS;
        end
        return src;
    endfunction

endpackage

// File: rtl/zilla_mcyc_counter.sv
// Clearable up-counter with terminal-count compare; shared between the
// multiplier latency wait and the divider timeout.
module zilla_mcyc_counter #(
    parameter int unsigned WIDTH = 6
) (
    input  logic             ld_hz_ctrl_clk,
    input  logic             ld_hz_ctrl_rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] term_i,
    output logic             tc_o
);

    logic [WIDTH-1:0] cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ld_hz_ctrl_clk or negedge ld_hz_ctrl_rst) begin
        if (!ld_hz_ctrl_rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + WIDTH'(1);
        end
    end

    assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/zilla_muldiv_sched.sv
// RV32M multi-cycle scheduler: launches the pipelined multiplier or shared
// divider, stalls the pipeline while busy and sequences a one-cycle writeback.
module zilla_muldiv_sched
    import zilla_muldiv_pkg::*;
#(
    parameter int unsigned GPR_ADDR_WIDTH = 5,
    parameter int unsigned MUL_LATENCY    = 3,
    parameter int unsigned DIV_TIMEOUT    = 64
) (
    input  logic                      ld_hz_ctrl_clk,
    input  logic                      ld_hz_ctrl_rst,
    input  logic                      wdt_reset_i,
    input  logic                      req_valid_i,
    input  logic [2:0]                req_op_i,
    input  logic [GPR_ADDR_WIDTH-1:0] req_rd_i,
    input  logic                      req_div_zero_i,
    output logic                      req_ready_o,
    output logic                      mul_start_o,
    output logic                      div_start_o,
    output logic                      div_signed_o,
    input  logic                      div_done_i,
    output logic                      wb_valid_o,
    output logic                      wb_we_o,
    output logic [GPR_ADDR_WIDTH-1:0] wb_rd_o,
    output logic [1:0]                wb_src_o,
    output logic                      stall_o,
    output logic                      timeout_err_o
);

    localparam int unsigned CNT_MAX = (DIV_TIMEOUT > 16) ? DIV_TIMEOUT : 16;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] MUL_TC = CNT_W'(MUL_LATENCY - 1);
    localparam logic [CNT_W-1:0] DIV_TC = CNT_W'(DIV_TIMEOUT - 1);

    state_e                    state_q, state_d;
    logic [GPR_ADDR_WIDTH-1:0] rd_q, rd_d;
    wb_src_e                   src_q, src_d;
    logic                      cnt_clr, cnt_en, cnt_tc;
    logic [CNT_W-1:0]          cnt_term;
    logic                      accept;

    zilla_mcyc_counter #(.WIDTH(CNT_W)) u_cnt (
        .ld_hz_ctrl_clk (ld_hz_ctrl_clk),
        .ld_hz_ctrl_rst (ld_hz_ctrl_rst),
        .clr_i          (cnt_clr),
        .en_i           (cnt_en),
        .term_i         (cnt_term),
        .tc_o           (cnt_tc)
    );

    always_ff @(posedge ld_hz_ctrl_clk or negedge ld_hz_ctrl_rst) begin
        if (!ld_hz_ctrl_rst) begin
            state_q <= ST_IDLE;
            rd_q    <= '0;
            src_q   <= WB_MUL;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            src_q   <= src_d;
        end
    end

    assign accept = (state_q == ST_IDLE) && req_valid_i && !wdt_reset_i;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        rd_d          = rd_q;
        src_d         = src_q;
        cnt_clr       = 1'b0;
        cnt_en        = 1'b0;
        cnt_term      = MUL_TC;
        mul_start_o   = 1'b0;
        div_start_o   = 1'b0;
        div_signed_o  = 1'b0;
        timeout_err_o = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    rd_d    = req_rd_i;
                    src_d   = op_to_src(req_op_i, req_div_zero_i);
                    cnt_clr = 1'b1;
                    if (!req_op_i[2]) begin
                        mul_start_o = 1'b1;
                        state_d     = ST_MUL;
                    end else if (req_div_zero_i) begin
                        state_d = ST_WB;
                    end else begin
                        div_start_o  = 1'b1;
                        div_signed_o = ~req_op_i[0];
                        state_d      = ST_DIV;
                    end
                end
            end
            ST_MUL: begin
                cnt_en   = 1'b1;
                cnt_term = MUL_TC;
                if (cnt_tc) begin
                    state_d = ST_WB;
                end
            end
            ST_DIV: begin
                cnt_en   = 1'b1;
                cnt_term = DIV_TC;
                // A result arriving on the last allowed cycle beats the timeout.
                if (div_done_i) begin
                    state_d = ST_WB;
                end else if (cnt_tc) begin
                    timeout_err_o = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (wdt_reset_i) begin
            state_d       = ST_IDLE;
            rd_d          = '0;
            src_d         = WB_MUL;
            cnt_clr       = 1'b1;
            timeout_err_o = 1'b0;
        end
    end

    assign req_ready_o = (state_q == ST_IDLE);
    assign stall_o     = (state_q == ST_MUL) || (state_q == ST_DIV) ||
                         ((state_q == ST_IDLE) && req_valid_i);
    assign wb_valid_o  = (state_q == ST_WB);
    assign wb_we_o     = (state_q == ST_WB) && (|rd_q);
    assign wb_rd_o     = rd_q;
    assign wb_src_o    = src_q;

endmodule

// File: tb/tb_zilla_muldiv_sched.sv
// Self-checking bench for zilla_muldiv_sched: vector table, directed
// multi-cycle sequences and a randomized run against a cycle-level model.
module tb_zilla_muldiv_sched;

    localparam int AW  = 5;
    localparam int LAT = 3;
    localparam int TO  = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          wdt, valid, dz, done;
    logic [2:0]    op;
    logic [AW-1:0] rd;
    logic          ready, mul_s, div_s, div_sg, wbv, wbwe, stall, tout;
    logic [AW-1:0] wb_rd;
    logic [1:0]    wb_src;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    zilla_muldiv_sched #(
        .GPR_ADDR_WIDTH (AW),
        .MUL_LATENCY    (LAT),
        .DIV_TIMEOUT    (TO)
    ) dut (
        .ld_hz_ctrl_clk (clk),
        .ld_hz_ctrl_rst (rst),
        .wdt_reset_i    (wdt),
        .req_valid_i    (valid),
        .req_op_i       (op),
        .req_rd_i       (rd),
        .req_div_zero_i (dz),
        .req_ready_o    (ready),
        .mul_start_o    (mul_s),
        .div_start_o    (div_s),
        .div_signed_o   (div_sg),
        .div_done_i     (done),
        .wb_valid_o     (wbv),
        .wb_we_o        (wbwe),
        .wb_rd_o        (wb_rd),
        .wb_src_o       (wb_src),
        .stall_o        (stall),
        .timeout_err_o  (tout)
    );

    typedef struct {
        logic [2:0]    op;
        logic          dz;
        logic [AW-1:0] rd;
        int            done_delay;
        int            exp_lat;
        logic          exp_wb;
        logic [1:0]    exp_src;
        logic          exp_mul_start;
        logic          exp_div_start;
        logic          exp_signed;
    } vec_t;

    vec_t vecs[$];

    // Reference-model state: what the block is doing, in spec terms.
    bit            m_mul, m_div, m_wb;
    int            m_mul_left, m_div_age;
    logic [AW-1:0] m_rd;
    logic [1:0]    m_src;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [14:0] outs();
        return {ready, mul_s, div_s, div_sg, wbv, wbwe, wb_rd, wb_src, stall, tout};
    endfunction

    function automatic logic [1:0] src_of(input logic [2:0] o, input logic z);
        if (!o[2])     return 2'b00;
        else if (z)    return 2'b11;
        else if (o[1]) return 2'b10;
        else           return 2'b01;
    endfunction

    task automatic clear_inputs();
        wdt = 1'b0; valid = 1'b0; op = '0; rd = '0; dz = 1'b0; done = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic goto_cycle(input int n);
        while (cyc < n) step();
    endtask

    task automatic do_reset(input bit check_state);
        clear_inputs();
        rst = 1'b0;
        if (check_state) begin
            sample();
            check("reset_outputs", 32'(outs()), 32'(15'h4000));
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        cyc = 0;
        m_mul = 0; m_div = 0; m_wb = 0; m_mul_left = 0; m_div_age = 0;
        m_rd = '0; m_src = '0;
    endtask

    task automatic run_vector(input vec_t v, input int idx);
        int  c0, lat;
        bit  ev_wb, ev_to;
        logic [1:0] got_src;
        logic got_we;
        valid = 1'b1; op = v.op; rd = v.rd; dz = v.dz;
        sample();
        check($sformatf("vec%0d_starts", idx), {29'd0, mul_s, div_s, div_sg},
              {29'd0, v.exp_mul_start, v.exp_div_start, v.exp_signed});
        c0 = cyc;
        lat = -1; ev_wb = 0; ev_to = 0; got_src = '0; got_we = 1'b0;
        step();
        valid = 1'b0; dz = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            done = (v.done_delay != 0) && (cyc == c0 + v.done_delay);
            sample();
            if (wbv || tout) begin
                lat = k; ev_wb = wbv; ev_to = tout; got_src = wb_src; got_we = wbwe;
                break;
            end
            step();
        end
        done = 1'b0;
        check($sformatf("vec%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
        check($sformatf("vec%0d_kind", idx), {30'd0, ev_wb, ev_to}, {30'd0, v.exp_wb, !v.exp_wb});
        if (v.exp_wb) begin
            check($sformatf("vec%0d_src_we", idx), {29'd0, got_src, got_we},
                  {29'd0, v.exp_src, v.rd != 0});
        end
        step();
        sample();
        check($sformatf("vec%0d_ready_after", idx), 32'(ready), 32'd1);
        step();
    endtask

    task automatic add_vec(input logic [2:0] o, input logic z, input logic [AW-1:0] r,
                           input int dd, input int lat, input logic wb);
        vec_t v;
        v.op = o; v.dz = z; v.rd = r; v.done_delay = dd; v.exp_lat = lat; v.exp_wb = wb;
        v.exp_src = src_of(o, z);
        v.exp_mul_start = !o[2];
        v.exp_div_start = o[2] && !z;
        v.exp_signed    = o[2] && !z && !o[0];
        vecs.push_back(v);
    endtask

    initial begin
        logic [14:0] exp_o;
        bit idle, acc, nwb;
        int t;

        // op, dz, rd, done delay, cycles accept->WB/timeout, WB expected
        add_vec(3'b000, 1'b0, 5'd3,  0,  LAT + 1, 1'b1);
        add_vec(3'b001, 1'b1, 5'd7,  0,  LAT + 1, 1'b1);
        add_vec(3'b010, 1'b0, 5'd31, 0,  LAT + 1, 1'b1);
        add_vec(3'b011, 1'b0, 5'd0,  0,  LAT + 1, 1'b1);
        add_vec(3'b100, 1'b0, 5'd1,  1,  2,       1'b1);
        add_vec(3'b101, 1'b0, 5'd9,  10, 11,      1'b1);
        add_vec(3'b110, 1'b0, 5'd12, 3,  4,       1'b1);
        add_vec(3'b111, 1'b0, 5'd2,  5,  6,       1'b1);
        add_vec(3'b101, 1'b1, 5'd4,  0,  1,       1'b1);
        add_vec(3'b111, 1'b1, 5'd0,  0,  1,       1'b1);
        add_vec(3'b100, 1'b0, 5'd6,  TO, TO + 1,  1'b1);
        add_vec(3'b110, 1'b0, 5'd8,  TO + 1, TO,  1'b0);
        add_vec(3'b100, 1'b0, 5'd8,  0,  TO,      1'b0);

        do_reset(1'b1);
        sample();
        check("post_reset_idle", 32'(outs()), 32'(15'h4000));
        step();
        foreach (vecs[i]) run_vector(vecs[i], i);

        // MUL accepted at cycle 10.
        do_reset(1'b0);
        goto_cycle(10);
        valid = 1'b1; op = 3'b000; rd = 5'd5;
        sample();
        check("mul_start_t10", {30'd0, mul_s, stall}, 32'd3);
        step();
        valid = 1'b0;
        for (int c = 11; c <= 13; c++) begin
            sample();
            check($sformatf("mul_busy_c%0d", c), {29'd0, stall, wbv, ready}, 32'b100);
            step();
        end
        sample();
        check("mul_wb_c14", {25'd0, wbv, wbwe, wb_rd, stall},
              {25'd0, 1'b1, 1'b1, 5'd5, 1'b0});
        check("mul_wb_src_c14", 32'(wb_src), 32'd0);

        // DIVU accepted at 5, done at 20.
        do_reset(1'b0);
        goto_cycle(5);
        valid = 1'b1; op = 3'b101; rd = 5'd17;
        sample();
        check("divu_start_c5", {30'd0, div_s, div_sg}, 32'b10);
        step();
        valid = 1'b0;
        goto_cycle(20);
        done = 1'b1;
        sample();
        check("divu_c20_busy", {30'd0, wbv, stall}, 32'b01);
        step();
        done = 1'b0;
        sample();
        check("divu_wb_c21", {28'd0, wbv, wb_src, stall}, {28'd0, 1'b1, 2'b01, 1'b0});

        // REM with zero divisor at 8.
        do_reset(1'b0);
        goto_cycle(8);
        valid = 1'b1; op = 3'b110; rd = 5'd10; dz = 1'b1;
        sample();
        check("remz_no_start_c8", {30'd0, div_s, mul_s}, 32'd0);
        step();
        valid = 1'b0; dz = 1'b0;
        sample();
        check("remz_wb_c9", {29'd0, wbv, wb_src}, {29'd0, 1'b1, 2'b11});

        // DIV that never completes: timeout at accept+64.
        do_reset(1'b0);
        goto_cycle(2);
        valid = 1'b1; op = 3'b100; rd = 5'd3;
        sample();
        step();
        valid = 1'b0;
        t = 0;
        while (cyc < 2 + TO) begin
            sample();
            if (tout || wbv) t++;
            step();
        end
        check("div_no_early_timeout", 32'(t), 32'd0);
        sample();
        check("div_timeout_c66", {30'd0, tout, wbv}, 32'b10);
        step();
        sample();
        check("div_timeout_ready_c67", {29'd0, ready, wbv, tout}, 32'b100);

        // Watchdog in the 3rd DIV cycle.
        do_reset(1'b0);
        goto_cycle(3);
        valid = 1'b1; op = 3'b100; rd = 5'd21;
        sample();
        step();
        valid = 1'b0;
        goto_cycle(6);
        wdt = 1'b1;
        sample();
        step();
        wdt = 1'b0;
        sample();
        check("wdt_idle_c7", {24'd0, ready, stall, tout, wb_rd}, {24'd0, 1'b1, 1'b0, 1'b0, 5'd0});
        step();
        done = 1'b1;
        sample();
        step();
        done = 1'b0;
        sample();
        check("wdt_done_ignored_c9", {30'd0, wbv, ready}, 32'b01);

        // MUL to rd=0, then done/timeout tie.
        do_reset(1'b0);
        valid = 1'b1; op = 3'b011; rd = 5'd0;
        sample();
        step();
        valid = 1'b0;
        goto_cycle(LAT + 1);
        sample();
        check("mul_rd0_wb", {30'd0, wbv, wbwe}, 32'b10);
        step();
        step();
        t = cyc;
        valid = 1'b1; op = 3'b100; rd = 5'd11;
        sample();
        step();
        valid = 1'b0;
        goto_cycle(t + TO);
        done = 1'b1;
        sample();
        check("tie_no_timeout", 32'(tout), 32'd0);
        step();
        done = 1'b0;
        sample();
        check("tie_wb", {29'd0, wbv, wb_src}, {29'd0, 1'b1, 2'b01});

        // Randomized run against the cycle-level model.
        do_reset(1'b0);
        for (int n = 0; n < 4000; n++) begin
            valid = ($urandom_range(0, 2) != 0);
            op    = 3'($urandom);
            rd    = AW'($urandom);
            dz    = ($urandom_range(0, 5) == 0);
            done  = ($urandom_range(0, 24) == 0);
            wdt   = ($urandom_range(0, 149) == 0);
            sample();
            idle = !m_mul && !m_div && !m_wb;
            acc  = idle && valid && !wdt;
            exp_o = {idle, acc && !op[2], acc && op[2] && !dz, acc && op[2] && !dz && !op[0],
                     m_wb, m_wb && (m_rd != 0), m_rd, m_src,
                     m_mul || m_div || (idle && valid),
                     m_div && !done && !wdt && (m_div_age == TO - 1)};
            check("random_outputs", 32'(outs()), 32'(exp_o));
            if (wdt) begin
                m_mul = 0; m_div = 0; m_wb = 0; m_mul_left = 0; m_div_age = 0;
                m_rd = '0; m_src = '0;
            end else begin
                nwb = (m_mul && m_mul_left == 1) || (m_div && done) || (acc && op[2] && dz);
                if (m_mul) begin
                    m_mul_left--;
                    if (m_mul_left == 0) m_mul = 0;
                end
                if (m_div) begin
                    if (done || m_div_age == TO - 1) m_div = 0;
                    else m_div_age++;
                end
                if (acc) begin
                    m_rd  = rd;
                    m_src = src_of(op, dz);
                    if (!op[2]) begin
                        m_mul = 1; m_mul_left = LAT;
                    end else if (!dz) begin
                        m_div = 1; m_div_age = 0;
                    end
                end
                m_wb = nwb;
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
